unsigned_serial_divider: RTL
============================

UNSIGNED_SERIAL_DIVIDER -- requirements
Module: unsigned_serial_divider

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, setting the operand and result width (legal range 2..64).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: single-cycle request pulse from the requester.
REQ-005 SHALL have port dividend, input, DATA_WIDTH bits: numerator, sampled only with an accepted start.
REQ-006 SHALL have port divisor, input, DATA_WIDTH bits: denominator, sampled only with an accepted start.
REQ-007 SHALL have port quotient, output, DATA_WIDTH bits: unsigned quotient result.
REQ-008 SHALL have port remainder, output, DATA_WIDTH bits: unsigned remainder result.
REQ-009 SHALL have port done, output, 1 bit: single-cycle pulse marking quotient/remainder valid.
REQ-010 SHALL have port divisor_is_zero, output, 1 bit: registered flag, divisor of the current/last operation was 0.
REQ-011 SHALL present exactly the divider side of unsigned_division_interface; no other ports.

Function
REQ-012 SHALL implement a two-state FSM, IDLE and BUSY, plus a cycle counter of clog2(DATA_WIDTH)+1 bits.
REQ-013 SHALL accept start only when the state is IDLE, including the cycle in which done is high; start in BUSY SHALL be ignored with no effect on state, operands or outputs.
REQ-014 On an accepted start (edge E0), SHALL load Q<=dividend, R<=0 (DATA_WIDTH+1 bits), D<=divisor, counter<=0, divisor_is_zero<=(divisor==0), and go to BUSY.
REQ-015 In BUSY, each edge SHALL perform one restoring step: shift {R,Q} left by 1; trial=R-{1'b0,D}; if trial is non-negative, R<=trial and Q[0]<=1, else R keeps the shifted value and Q[0]<=0.
REQ-016 SHALL perform exactly DATA_WIDTH steps, on edges E1..E_DATA_WIDTH; at edge E_DATA_WIDTH the FSM SHALL return to IDLE and set done<=1.
REQ-017 done SHALL be high for exactly one cycle (E_DATA_WIDTH to E_DATA_WIDTH+1) per accepted start; fixed latency DATA_WIDTH cycles, independent of operand values.
REQ-018 quotient SHALL equal Q and remainder SHALL equal R[DATA_WIDTH-1:0]; both are valid when done is high and held stable until the next accepted start.
REQ-019 With divisor 0, SHALL naturally produce quotient all-ones and remainder=dividend at normal latency, with divisor_is_zero=1; no special-case path.
REQ-020 divisor_is_zero SHALL hold its value from the accepting edge until the next accepted start.
REQ-021 If start arrives in the done cycle, SHALL accept it: done drops the next cycle, and the new result arrives DATA_WIDTH cycles later.
REQ-022 SHALL have no combinational path from any input to any output.

Reset
REQ-023 While rst_n is low, SHALL asynchronously force state=IDLE, counter=0, done=0, divisor_is_zero=0, quotient=0, remainder=0.
REQ-024 Reset asserted mid-operation SHALL abort the operation; no done pulse SHALL follow for the aborted request.
REQ-025 After rst_n deasserts, SHALL accept a start on the first rising edge.

Verification
REQ-026 W=32: start with 100/7 -> done exactly 32 cycles later for 1 cycle; quotient=14, remainder=2, divisor_is_zero=0.
REQ-027 W=32: start with 5/0 -> after 32 cycles quotient=0xFFFFFFFF, remainder=5, divisor_is_zero=1; 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0; 3/10 -> quotient=0, remainder=3.
REQ-028 W=32: start 1000/3, then a second start with 9/9 at cycle 10 -> the second is ignored; single done at cycle 32 with quotient=333, remainder=1.
REQ-029 Back-to-back: start 1000/3, then 9/9 during the done cycle -> second done 32 cycles later with quotient=1, remainder=0; exactly two done pulses.
REQ-030 Reset: start 100/7, drop rst_n at cycle 15 -> outputs zero immediately; no done for 40 cycles after release; a fresh 100/7 then completes correctly.

Source files
------------

// File: rtl/unsigned_serial_divider.sv
// Unsigned restoring divider, one quotient bit per clock.
// A start accepted in IDLE loads the operands; DATA_WIDTH restoring steps
// follow, then done pulses for one cycle with quotient/remainder valid.
// Results stay on the outputs until the next accepted start.
module unsigned_serial_divider #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  done,
  output logic                  divisor_is_zero
);

  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  // Counter value during the final restoring step.
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_WIDTH - 1);

  logic [0:0]            state_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic [DATA_WIDTH-1:0] q_reg;
  logic [DATA_WIDTH:0]   r_reg;
  logic [DATA_WIDTH-1:0] d_reg;
  logic                  done_reg;
  logic                  dz_reg;

  // One restoring step: the partial remainder is widened by one extra bit so
  // that the sign of the trial subtraction is visible in its top bit.
  logic [DATA_WIDTH+1:0] shift_rem;
  logic [DATA_WIDTH+1:0] trial;
  logic                  trial_ok;
  logic [DATA_WIDTH:0]   r_next;
  logic [DATA_WIDTH-1:0] q_next;

  // Combinational restoring step on the current {R,Q} pair.
  always_comb begin
    shift_rem = {r_reg, q_reg[DATA_WIDTH-1]};
    trial     = shift_rem - {2'b00, d_reg};
    trial_ok  = ~trial[DATA_WIDTH+1];
    r_next    = trial_ok ? trial[DATA_WIDTH:0] : shift_rem[DATA_WIDTH:0];
    q_next    = {q_reg[DATA_WIDTH-2:0], trial_ok};
  end

  // FSM, operand registers and step counter; done is a one-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      q_reg     <= '0;
      r_reg     <= '0;
      d_reg     <= '0;
      done_reg  <= 1'b0;
      dz_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            q_reg     <= dividend;
            r_reg     <= '0;
            d_reg     <= divisor;
            cnt_reg   <= '0;
            dz_reg    <= (divisor == '0);
            state_reg <= BUSY;
          end
        end
        BUSY: begin
          q_reg   <= q_next;
          r_reg   <= r_next;
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (cnt_reg == LAST_STEP) begin
            state_reg <= IDLE;
            done_reg  <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign quotient        = q_reg;
  assign remainder       = r_reg[DATA_WIDTH-1:0];
  assign done            = done_reg;
  assign divisor_is_zero = dz_reg;

endmodule
